visualizador_7seg_bcd: RTL and testbench

// - Downstream stage of the BCD converter: latches the 20-bit BCD result and sign on the converter's done pulse.
// - Time-multiplexes them onto an 8-digit, common-anode 7-segment display.
// - Digits 0-4 show BCD nibbles 0-4 (digit 0 = units), digit 5 shows '-' when negative, digits 6-7 are off.
// - Sits between the binary-to-BCD converter and the board display pins.

---
 rtl/visualizador_7seg_bcd.sv | 124 ++++++++++++
 tb/tb_visualizador_7seg_bcd.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/visualizador_7seg_bcd.sv
// visualizador_7seg_bcd: latches a 5-digit BCD result and sign, then scans it onto an
// 8-digit common-anode 7-segment display. Define BLANK_CEROS_IZQ_EN for leading-zero blanking.
module visualizador_7seg_bcd #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] codigo_BCD,
  input  logic        signo,
  input  logic        done,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        valido
);

  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [6:0]       SEG_DASH = 7'b0111111;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [19:0]      bcd_q;
  logic             signo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;

  logic [3:0]       nib;
  logic [2:0]       ndig;
  logic [7:0]       an_d;
  logic [6:0]       seg_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0000110;  // 'E' flags a non-BCD nibble
    endcase
  endfunction

  // Capture: last strobe wins, value held between strobes.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q   <= '0;
      signo_q <= 1'b0;
      valido  <= 1'b0;
    end else if (done) begin
      bcd_q   <= codigo_BCD;
      signo_q <= signo;
      valido  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ndig = number of displayed magnitude digits; the sign sits at index ndig.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nib = 4'd0;
    case (idx_q)
      3'd0:    nib = bcd_q[3:0];
      3'd1:    nib = bcd_q[7:4];
      3'd2:    nib = bcd_q[11:8];
      3'd3:    nib = bcd_q[15:12];
      3'd4:    nib = bcd_q[19:16];
      default: nib = 4'd0;
    endcase

`ifdef BLANK_CEROS_IZQ_EN
    ndig = 3'd1;
    if (bcd_q[7:4]   != 4'd0) ndig = 3'd2;
    if (bcd_q[11:8]  != 4'd0) ndig = 3'd3;
    if (bcd_q[15:12] != 4'd0) ndig = 3'd4;
    if (bcd_q[19:16] != 4'd0) ndig = 3'd5;
`else
    ndig = 3'd5;
`endif

    an_d  = 8'hFF;
    seg_d = SEG_OFF;
    if (idx_q <= 3'd5) begin
      an_d = ~(8'd1 << idx_q);
      if (!valido) begin
        if (idx_q != 3'd5) seg_d = SEG_DASH;
      end else if (idx_q < ndig) begin
        seg_d = glyph(nib);
      end else if (idx_q == ndig && signo_q) begin
        seg_d = SEG_DASH;
      end
    end
  end

  // an and seg share one register stage so they always switch on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_visualizador_7seg_bcd.sv
// Self-checking bench for visualizador_7seg_bcd with REFRESH_DIV=4; compares every scanned
// digit against a positional model of the display driven by random BCD captures.
module tb_visualizador_7seg_bcd;

  localparam int R = 4;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'h7F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] codigo_BCD = '0;
  logic        signo = 1'b0;
  logic        done = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        valido;

  visualizador_7seg_bcd #(.REFRESH_DIV(R), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .codigo_BCD(codigo_BCD), .signo(signo), .done(done),
    .an(an), .seg(seg), .dp(dp), .valido(valido)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the output after edge k shows digit ((k-1)/R) mod 8.
  int cyc;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [19:0] m_bcd = '0;
  logic        m_sign = 1'b0;
  logic        m_valid = 1'b0;

  function automatic logic [6:0] glyph(int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b0000110;
    endcase
  endfunction

  function automatic int scan_idx();
    if (cyc == 0) return -1;
    return ((cyc - 1) / R) % 8;
  endfunction

  function automatic int digit(int k);
    return (int'(m_bcd) / (16 ** k)) % 16;
  endfunction

  function automatic logic [7:0] model_an(int i);
    if (i < 0 || i > 5) return 8'hFF;
    return ~(8'd1 << i);
  endfunction

  function automatic logic [6:0] model_seg(int i);
    int ndig;
    if (i < 0 || i > 5) return OFF;
    if (!m_valid) return (i < 5) ? DASH : OFF;
    ndig = 5;
`ifdef BLANK_CEROS_IZQ_EN
    ndig = 1;
    for (int k = 1; k < 5; k++) if (digit(k) != 0) ndig = k + 1;
`endif
    if (i < ndig) return glyph(digit(i));
    if (i == ndig && m_sign) return DASH;
    return OFF;
  endfunction

  function automatic int lit_index(logic [7:0] a);
    if (a == 8'hFF) return -1;
    for (int i = 0; i < 8; i++) if (a == ~(8'd1 << i)) return i;
    return -2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [19:0] v, input logic s);
    @(negedge clk);
    done = 1'b1; codigo_BCD = v; signo = s;
    step();
    m_bcd = v; m_sign = s; m_valid = 1'b1;
    checks++;
    if (valido !== 1'b1) begin
      failures++; $display("FAIL capture_valido got=%b want=1", valido);
    end
    @(negedge clk);
    done = 1'b0; codigo_BCD = $urandom; signo = $urandom_range(0, 1);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== OFF || dp !== 1'b1 || valido !== 1'b0) begin
      failures++; $display("FAIL reset_init an=%h seg=%b dp=%b valido=%b", an, seg, dp, valido);
    end
    @(negedge clk) reset = 1'b0;
    for (int n = 0; n < 11; n++) step();
    #2 reset = 1'b1;
    #1;
    m_bcd = '0; m_sign = 1'b0; m_valid = 1'b0;
    checks++;
    if (an !== 8'hFF || seg !== OFF || valido !== 1'b0) begin
      failures++; $display("FAIL reset_midscan an=%h seg=%b valido=%b", an, seg, valido);
    end
    @(negedge clk) reset = 1'b0;
    step();
    checks++;
    if (an !== 8'hFE || seg !== DASH || valido !== 1'b0) begin
      failures++; $display("FAIL reset_release an=%h seg=%b valido=%b want an=fe seg=%b", an, seg, valido, DASH);
    end
    for (int n = 0; n < 31; n++) begin
      step();
      checks++;
      if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx())) begin
        failures++; $display("FAIL idle_scan idx=%0d an=%h seg=%b want an=%h seg=%b",
                             scan_idx(), an, seg, model_an(scan_idx()), model_seg(scan_idx()));
      end
    end
  endtask

  task automatic test_capture();
    capture(20'h01234, 1'b0);
    for (int n = 0; n < 8 * R; n++) begin
      step();
      checks++;
      if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx()) || dp !== 1'b1) begin
        failures++; $display("FAIL capture_scan idx=%0d an=%h seg=%b dp=%b want an=%h seg=%b",
                             scan_idx(), an, seg, dp, model_an(scan_idx()), model_seg(scan_idx()));
      end
      if (scan_idx() == 0) begin
        checks++;
        if (seg !== 7'b0011001) begin
          failures++; $display("FAIL capture_idx0 seg=%b want=0011001", seg);
        end
      end
    end
  endtask

  task automatic test_negative();
    capture(20'h0A019, 1'b1);
    for (int n = 0; n < 8 * R; n++) begin
      step();
      checks++;
      if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx())) begin
        failures++; $display("FAIL negative_scan idx=%0d an=%h seg=%b want an=%h seg=%b",
                             scan_idx(), an, seg, model_an(scan_idx()), model_seg(scan_idx()));
      end
      if (scan_idx() == 3) begin
        checks++;
        if (seg !== 7'b0000110) begin
          failures++; $display("FAIL negative_E seg=%b want=0000110", seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    done = 1'b1; codigo_BCD = 20'h00001; signo = 1'b1;
    @(negedge clk);
    codigo_BCD = 20'h00002; signo = 1'b0;
    @(negedge clk);
    done = 1'b0; codigo_BCD = 20'h99999; signo = 1'b1;
    m_bcd = 20'h00002; m_sign = 1'b0; m_valid = 1'b1;
    for (int n = 0; n < 8 * R; n++) begin
      step();
      checks++;
      if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx())) begin
        failures++; $display("FAIL back_to_back idx=%0d an=%h seg=%b want an=%h seg=%b",
                             scan_idx(), an, seg, model_an(scan_idx()), model_seg(scan_idx()));
      end
    end
  endtask

  task automatic test_scan_timing();
    logic [7:0] prev;
    int run, lp, ln;
    bit started;
    step();
    prev = an; run = 1; started = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (an === prev) run++;
      else begin
        if (started) begin
          checks++;
          if (run != ((prev == 8'hFF) ? 2 * R : R)) begin
            failures++; $display("FAIL scan_run an=%h cycles=%0d want=%0d", prev, run, (prev == 8'hFF) ? 2 * R : R);
          end
        end
        lp = lit_index(prev); ln = lit_index(an);
        checks++;
        if (ln != ((lp == 5) ? -1 : lp + 1) || lp == -2) begin
          failures++; $display("FAIL scan_order from=%h to=%h", prev, an);
        end
        started = 1'b1; prev = an; run = 1;
      end
    end
  endtask

  task automatic test_random();
    logic [19:0] v;
    int nd, nb;
    for (int it = 0; it < 20; it++) begin
      v = '0;
      nd = $urandom_range(0, 5);
      for (int k = 0; k < nd; k++) begin
        nb = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        v = v + 20'(nb * (16 ** k));
      end
      for (int w = $urandom_range(0, 9); w > 0; w--) step();
      capture(v, 1'($urandom_range(0, 1)));
      for (int n = 0; n < 8 * R; n++) begin
        step();
        checks++;
        if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx())) begin
          failures++; $display("FAIL random v=%h s=%b idx=%0d an=%h seg=%b want an=%h seg=%b",
                               m_bcd, m_sign, scan_idx(), an, seg, model_an(scan_idx()), model_seg(scan_idx()));
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] want2;
`ifdef BLANK_CEROS_IZQ_EN
    want2 = DASH;
`else
    want2 = glyph(0);
`endif
    capture(20'h00042, 1'b1);
    for (int n = 0; n < 8 * R; n++) begin
      step();
      checks++;
      if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx())) begin
        failures++; $display("FAIL blank_42 idx=%0d an=%h seg=%b want seg=%b", scan_idx(), an, seg, model_seg(scan_idx()));
      end
      if (scan_idx() == 2) begin
        checks++;
        if (seg !== want2) begin
          failures++; $display("FAIL blank_idx2 seg=%b want=%b", seg, want2);
        end
      end
    end
    capture(20'h00000, 1'b0);
    for (int n = 0; n < 8 * R; n++) begin
      step();
      checks++;
      if (an !== model_an(scan_idx()) || seg !== model_seg(scan_idx())) begin
        failures++; $display("FAIL blank_zero idx=%0d an=%h seg=%b want seg=%b", scan_idx(), an, seg, model_seg(scan_idx()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_negative();
    test_back_to_back();
    test_scan_timing();
    test_random();
    test_blanking();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
